// File: rtl/ws2812_pkg.sv
// Shared types and 50 MHz timing defaults for the WS2812 receive path.
package ws2812_pkg;

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    localparam int BITS_PER_PIXEL   = 24;

    localparam int DEF_T_BIT_THRESH = 30;
    localparam int DEF_T_MAX_HIGH   = 75;
    localparam int DEF_T_RESET      = 2500;
    localparam int DEF_CNT_W        = 12;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// Decodes a WS2812 pulse-width stream into 24-bit GRB pixels, pixel indices
// and frame-end strobes, with resynchronisation on protocol errors.
module ws2812_rx_decoder
    import ws2812_pkg::*;
#(
    parameter int T_BIT_THRESH = DEF_T_BIT_THRESH,
    parameter int T_MAX_HIGH   = DEF_T_MAX_HIGH,
    parameter int T_RESET      = DEF_T_RESET,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_index,
    output logic        frame_done,
    output logic        err
);

    // The counter restarts the cycle after an edge is seen: a high pulse of N
    // cycles leaves it at N-1, and T_RESET low cycles leave it at T_RESET-2.
    localparam logic [CNT_W-1:0] L_BIT_THRESH = CNT_W'(T_BIT_THRESH);
    localparam logic [CNT_W-1:0] L_MAX_HIGH   = CNT_W'(T_MAX_HIGH);
    localparam logic [CNT_W-1:0] L_GAP        = CNT_W'(T_RESET - 2);
    localparam logic [4:0]       L_LAST_BIT   = 5'(BITS_PER_PIXEL - 1);

    logic                       w_din_s;
    logic                       r_din_d;
    logic                       w_rise;
    logic                       w_fall;
    logic [CNT_W-1:0]           r_cnt;
    state_t                     r_state;
    state_t                     w_state_next;
    logic                       w_take_bit;
    logic                       w_bit_val;
    logic                       w_frame_end;
    logic                       w_proto_err;
    logic [4:0]                 r_bit_cnt;
    logic [7:0]                 r_pix_cnt;
    logic [BITS_PER_PIXEL-2:0]  r_shift;

    sync_2ff u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (din),
        .o_q   (w_din_s)
    );

    assign w_rise = !r_din_d &  w_din_s;
    assign w_fall =  r_din_d & !w_din_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_din_d <= w_din_s;
            if (w_rise || w_fall) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_take_bit   = 1'b0;
        w_bit_val    = (r_cnt >= L_BIT_THRESH);
        w_frame_end  = 1'b0;
        w_proto_err  = 1'b0;
        case (r_state)
            SYNC: begin
                if (!w_din_s && r_cnt >= L_GAP) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                if (w_rise) begin
                    w_state_next = HIGH;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_take_bit   = 1'b1;
                    w_state_next = LOW;
                end else if (r_cnt > L_MAX_HIGH) begin
                    w_proto_err  = 1'b1;
                    w_state_next = SYNC;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_state_next = HIGH;
                end else if (r_cnt >= L_GAP) begin
                    w_frame_end  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = SYNC;
        endcase
    end

    // Any error or frame end discards partial bits and restarts pixel numbering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_pix_cnt   <= '0;
            r_shift     <= '0;
            pixel_data  <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            if (w_take_bit) begin
                r_shift <= {r_shift[BITS_PER_PIXEL-3:0], w_bit_val};
                if (r_bit_cnt == L_LAST_BIT) begin
                    r_bit_cnt   <= '0;
                    pixel_data  <= {r_shift, w_bit_val};
                    pixel_valid <= 1'b1;
                    pixel_index <= r_pix_cnt;
                    if (r_pix_cnt != 8'hFF) begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if (w_frame_end) begin
                if (r_bit_cnt != '0) begin
                    err        <= 1'b1;
                    frame_done <= 1'b1;
                end else if (r_pix_cnt != '0) begin
                    frame_done <= 1'b1;
                end
                r_bit_cnt <= '0;
                r_pix_cnt <= '0;
            end
            if (w_proto_err) begin
                err       <= 1'b1;
                r_bit_cnt <= '0;
                r_pix_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for ws2812_rx_decoder: a protocol-level model queues the
// expected strobes while a monitor pops and compares them as the DUT emits.
module tb_ws2812_rx_decoder;

    localparam int T_BIT_THRESH = 30;
    localparam int T_MAX_HIGH   = 75;
    localparam int T_RESET      = 2500;

    localparam logic [2:0] EV_PIX = 3'b100;
    localparam logic [2:0] EV_FD  = 3'b010;
    localparam logic [2:0] EV_FDE = 3'b011;
    localparam logic [2:0] EV_ERR = 3'b001;

    typedef struct {
        logic [2:0]  flags;
        logic [23:0] data;
        logic [7:0]  index;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic        err;

    int  vectors     = 0;
    int  miscompares = 0;
    ev_t expQ[$];

    bit  m_synced = 1'b0;
    bit  m_bits[$];
    int  m_pix = 0;

    ws2812_rx_decoder #(
        .T_BIT_THRESH (T_BIT_THRESH),
        .T_MAX_HIGH   (T_MAX_HIGH),
        .T_RESET      (T_RESET),
        .CNT_W        (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic pushEv(input logic [2:0] f, input logic [23:0] d, input logic [7:0] idx);
        ev_t e;
        e.flags = f;
        e.data  = d;
        e.index = idx;
        expQ.push_back(e);
    endtask

    task automatic modelClear();
        m_bits.delete();
        m_pix = 0;
    endtask

    // Reference model: a pulse of h high cycles is a bit, a long one is an error.
    task automatic modelPulse(input int h);
        logic [23:0] v;
        if (!m_synced) return;
        if (h > T_MAX_HIGH) begin
            pushEv(EV_ERR, 24'h0, 8'h0);
            m_synced = 1'b0;
            modelClear();
            return;
        end
        m_bits.push_back(h > T_BIT_THRESH);
        if (m_bits.size() == 24) begin
            v = '0;
            for (int i = 0; i < 24; i++) begin
                v = v * 2 + 24'(m_bits[i]);
            end
            pushEv(EV_PIX, v, (m_pix > 255) ? 8'd255 : 8'(m_pix));
            m_pix++;
            m_bits.delete();
        end
    endtask

    task automatic modelLow(input int lo);
        if (lo < T_RESET) return;
        if (!m_synced) begin
            m_synced = 1'b1;
            return;
        end
        if (m_bits.size() != 0) begin
            pushEv(EV_FDE, 24'h0, 8'h0);
        end else if (m_pix > 0) begin
            pushEv(EV_FD, 24'h0, 8'h0);
        end
        modelClear();
    endtask

    task automatic applyStimulus(input int h, input int lo);
        modelPulse(h);
        modelLow(lo);
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic applyGap(input int lo);
        modelLow(lo);
        din = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // hi0 == 0 selects randomised pulse and gap widths.
    task automatic sendPixel(input logic [23:0] v, input int hi0, input int hi1, input int lastLo);
        for (int i = 23; i >= 0; i--) begin
            int h;
            int lo;
            if (hi0 == 0) begin
                h  = v[i] ? int'($urandom_range(70, 32)) : int'($urandom_range(29, 8));
                lo = int'($urandom_range(60, 8));
            end else begin
                h  = v[i] ? hi1 : hi0;
                lo = v[i] ? 22 : 42;
            end
            if (i == 0 && lastLo > 0) lo = lastLo;
            applyStimulus(h, lo);
        end
    endtask

    task automatic checkOutput();
        ev_t        e;
        logic [2:0] got;
        got = {pixel_valid, frame_done, err};
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_output: got flags=%b data=%h idx=%0d, required no output",
                     got, pixel_data, pixel_index);
            return;
        end
        e = expQ.pop_front();
        if (got != e.flags || (e.flags[2] && (pixel_data != e.data || pixel_index != e.index))) begin
            miscompares++;
            $display("[TB] FAIL strobe: got flags=%b data=%h idx=%0d, required flags=%b data=%h idx=%0d",
                     got, pixel_data, pixel_index, e.flags, e.data, e.index);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (pixel_valid || frame_done || err)) checkOutput();
        end
    end

    initial begin
        logic [23:0] rv;
        int          n;
        din = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if ({pixel_data, pixel_index, pixel_valid, frame_done, err} != 35'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got data=%h idx=%0d v=%b fd=%b err=%b, required all zero",
                     pixel_data, pixel_index, pixel_valid, frame_done, err);
        end
        rst = 1'b0;
        applyGap(2500);

        $display("[TB] single pixel");
        sendPixel(24'hFF0080, 20, 40, 2600);

        $display("[TB] three pixels in one frame");
        sendPixel(24'h000001, 20, 40, 0);
        sendPixel(24'h800000, 20, 40, 0);
        sendPixel(24'h123456, 20, 40, 2600);

        $display("[TB] partial pixel then full pixel");
        for (int i = 0; i < 10; i++) applyStimulus((i % 2) ? 40 : 20, (i == 9) ? 2600 : 30);
        sendPixel(24'h5A5A5A, 20, 40, 2600);

        $display("[TB] overlong high pulse then resync");
        applyStimulus(80, 22);
        sendPixel(24'hABCDEF, 20, 40, 2500);
        sendPixel(24'h0F0F0F, 20, 40, 2600);

        $display("[TB] threshold widths 30 and 31");
        sendPixel(24'hA5C33C, 30, 31, 2600);

        $display("[TB] empty reset gap");
        applyGap(2600);

        $display("[TB] reset mid-pixel");
        for (int i = 0; i < 12; i++) applyStimulus((i % 3 == 0) ? 40 : 20, 30);
        rst = 1'b1;
        m_synced = 1'b0;
        modelClear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sendPixel(24'h3C3C3C, 20, 40, 2500);
        sendPixel(24'hC0FFEE, 20, 40, 2600);

        $display("[TB] random frames");
        for (int f = 0; f < 3; f++) begin
            n = int'($urandom_range(3, 1));
            for (int p = 0; p < n; p++) begin
                rv = 24'($urandom());
                sendPixel(rv, 0, 0, (p == n - 1) ? 2600 : 0);
            end
        end

        $display("[TB] random pixel plus partial");
        rv = 24'($urandom());
        sendPixel(rv, 0, 0, 0);
        n = int'($urandom_range(23, 1));
        for (int i = 0; i < n; i++) begin
            applyStimulus(($urandom() & 1) ? int'($urandom_range(70, 32)) : int'($urandom_range(29, 8)),
                          (i == n - 1) ? 2600 : int'($urandom_range(60, 8)));
        end

        repeat (100) @(negedge clk);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL missing_output: got %0d strobes outstanding, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
